// File: rtl/demux1to5_width32_buf.sv
// Registered 1-to-5 demultiplexor: routes one input word to one of five
// single-entry output channels, each with its own valid/ready handshake.
module demux1to5_width32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [CNT_W-1:0] bad_sel_cnt
);

  logic             sel_bad;
  logic [2:0]       dst;
  logic [4:0]       dst_oh;
  logic             accept;
  logic [WIDTH-1:0] data_q [5];

  // Out-of-range selects fall back to channel 0 so every select has a home.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    sel_bad = 1'b0;
    dst     = in_sel;
    if (in_sel > 3'd4) begin
      sel_bad = 1'b1;
      dst     = 3'd0;
    end
  end

  assign dst_oh   = 5'b00001 << dst;
  assign in_ready = ~rst & (|(dst_oh & (~out_valid | out_ready)));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= '0;
      bad_sel_cnt <= '0;
      // NOTE: the holding registers are reset too, because their outputs are
      // visible and must read zero after reset, not stale data.
      for (int k = 0; k < 5; k++) data_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every channel's update reading the
      // pre-edge state, so drain and refill on one edge resolve correctly.
      for (int k = 0; k < 5; k++) begin
        if (accept && dst_oh[k]) begin
          data_q[k]    <= in_data;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (accept && sel_bad && (bad_sel_cnt != {CNT_W{1'b1}}))
        bad_sel_cnt <= bad_sel_cnt + 1'b1;
    end
  end

  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];
  assign out4 = data_q[4];

endmodule
